maple_tx_seq: RTL and testbench

//  Parametrised second-generation Maple bus transmitter. Drives pin1/pin5 and the
//  bus output enable from a byte FIFO. Generates the start pattern (configurable

---
 rtl/maple_tx_seq.sv | 187 ++++++++++++++++++
 tb/tb_maple_tx_seq.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/maple_tx_seq.sv
// maple_tx_seq: second-generation Maple bus transmitter.
// Pulls bytes from a TX FIFO and drives pin1/pin5 plus the pad output enable.
// Produces the start pattern, 32-step data cells (four phases per bit) and the end pattern.
// Also provides abort, a tick prescaler and a saturating per-frame byte counter.
// Optional feature: define MAPLE_TX_PARITY_EN to append an XOR parity byte before END.
module maple_tx_seq #(
  parameter int START_PULSES = 4,
  parameter int TICK_DIV     = 1,
  parameter int CNT_W        = 9
) (
  input  logic             clk,
  input  logic             rst,
  output logic             pin1,
  output logic             pin5,
  output logic             oe,
  output logic             start_active,
  output logic             end_active,
  input  logic             trigger_start,
  input  logic             trigger_end,
  input  logic             abort,
  input  logic             tick,
  input  logic [7:0]       fifo_data,
  input  logic             data_avail,
  output logic             data_consume,
  output logic [CNT_W-1:0] tx_count
);

  localparam int START_END  = 6 + 5 * START_PULSES;
  localparam int START_LAST = 7 + 5 * START_PULSES;
  localparam int PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_END} state_t;

  state_t        state;
  logic [6:0]    cnt;
  logic [PW-1:0] presc;
  logic [7:0]    latch;
  logic          latch_ready;
  logic          step;
  logic          trig_ok;
`ifdef MAPLE_TX_PARITY_EN
  logic [7:0]    parity;
`endif

  assign step         = tick && (presc == PW'(TICK_DIV - 1));
  assign trig_ok      = (trigger_start || trigger_end) && (state == S_IDLE || state == S_DATA);
  assign data_consume = data_avail & latch_ready;

  function automatic logic start_pin1(input logic [6:0] k);
    return (int'(k) < 3) || (int'(k) >= START_END);
  endfunction

  function automatic logic start_pin5(input logic [6:0] k);
    int d;
    d = int'(k) - 6;
    if (d >= 0 && int'(k) < START_END && (d % 5) < 2) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic end_pin1(input logic [6:0] k);
    return !(k == 7'd6 || k == 7'd7 || k == 7'd11 || k == 7'd12);
  endfunction

  function automatic logic end_pin5(input logic [6:0] k);
    return (k < 7'd3) || (k >= 7'd16);
  endfunction

  // Even bit slots (b7,b5,b3,b1) go out on pin5, odd slots on pin1.
  function automatic logic cell_pin5(input logic [6:0] k, input logic [7:0] b, input logic cur);
    if (k[2:0] == 3'd0) return b[3'd7 - k[4:2]];
    if (k[2:0] == 3'd3) return 1'b1;
    if (k[2:0] == 3'd6) return 1'b0;
    return cur;
  endfunction

  function automatic logic cell_pin1(input logic [6:0] k, input logic [7:0] b, input logic cur);
    if (k == 7'd31)     return 1'b1;
    if (k[2:0] == 3'd4) return b[3'd7 - k[4:2]];
    if (k[2:0] == 3'd2) return 1'b0;
    if (k[2:0] == 3'd7) return 1'b1;
    return cur;
  endfunction

  // Frame sequencer: triggers, byte latching, pattern stepping and line outputs.
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      state        <= S_IDLE;
      pin1         <= 1'b1;
      pin5         <= 1'b1;
      oe           <= 1'b0;
      start_active <= 1'b0;
      end_active   <= 1'b0;
      latch_ready  <= 1'b0;
      cnt          <= '0;
      presc        <= '0;
`ifdef MAPLE_TX_PARITY_EN
      parity       <= '0;
`endif
      if (rst) tx_count <= '0;
    end else begin
      if (trig_ok)   presc <= '0;
      else if (tick) presc <= step ? '0 : presc + PW'(1);

      if (data_consume) begin
        latch       <= fifo_data;
        latch_ready <= 1'b0;
`ifdef MAPLE_TX_PARITY_EN
        parity      <= parity ^ fifo_data;
`endif
      end

      if (trig_ok) begin
        oe           <= 1'b1;
        cnt          <= '0;
        start_active <= trigger_start;
        end_active   <= trigger_end;
        // A byte popped in this same cycle stays latched for the new frame.
        if ((trigger_start || !oe) && !data_consume) latch_ready <= 1'b1;
        if (trigger_start) begin
          tx_count <= '0;
`ifdef MAPLE_TX_PARITY_EN
          parity   <= data_consume ? fifo_data : 8'h00;
`endif
        end
        state <= trigger_start ? S_START : S_DATA;
      end else begin
        case (state)
          S_START: begin
            if (step) begin
              pin1 <= start_pin1(cnt);
              pin5 <= start_pin5(cnt);
              if (cnt == 7'(START_LAST)) begin
                start_active <= 1'b0;
                cnt          <= '0;
                state        <= S_DATA;
              end else begin
                cnt <= cnt + 7'd1;
              end
            end
          end
          S_DATA, S_PAR: begin
            if (state == S_DATA && latch_ready) begin
              if (end_active && !data_avail) begin
                cnt <= '0;
`ifdef MAPLE_TX_PARITY_EN
                latch       <= parity;
                latch_ready <= 1'b0;
                state       <= S_PAR;
`else
                state       <= S_END;
`endif
              end
            end else if (!latch_ready && step) begin
              pin1 <= cell_pin1(cnt, latch, pin1);
              pin5 <= cell_pin5(cnt, latch, pin5);
              if (cnt == 7'd31) begin
                cnt         <= '0;
                latch_ready <= 1'b1;
                if (state == S_PAR)       state    <= S_END;
                else if (tx_count != '1)  tx_count <= tx_count + CNT_W'(1);
              end else begin
                cnt <= cnt + 7'd1;
              end
            end
          end
          S_END: begin
            if (step) begin
              pin1 <= end_pin1(cnt);
              pin5 <= end_pin5(cnt);
              if (cnt >= 7'd16) begin
                end_active  <= 1'b0;
                latch_ready <= 1'b0;
                oe          <= 1'b0;
                cnt         <= '0;
                state       <= S_IDLE;
              end else begin
                cnt <= cnt + 7'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_maple_tx_seq.sv
// tb_maple_tx_seq: directed self-checking bench for maple_tx_seq.
// Expectations switch on MAPLE_TX_PARITY_EN to match the build being simulated.
module tb_maple_tx_seq;

  logic       clk = 1'b0;
  logic       rst, trigger_start, trigger_end, abort, tick, data_avail;
  logic [7:0] fifo_data;
  logic       pin1, pin5, oe, start_active, end_active, data_consume;
  logic [8:0] tx_count;
  logic       pin1_3, pin5_3, oe_3, start_active_3, end_active_3, data_consume_3;
  logic [8:0] tx_count_3;

  int checks = 0;
  int errors = 0;
  logic [7:0] q[$];

`ifdef MAPLE_TX_PARITY_EN
  localparam int END_DONE_CYCLES = 50;
`else
  localparam int END_DONE_CYCLES = 18;
`endif

  always #5 clk = ~clk;

  maple_tx_seq #(.START_PULSES(4), .TICK_DIV(1), .CNT_W(9)) dut (
    .clk(clk), .rst(rst), .pin1(pin1), .pin5(pin5), .oe(oe),
    .start_active(start_active), .end_active(end_active),
    .trigger_start(trigger_start), .trigger_end(trigger_end), .abort(abort),
    .tick(tick), .fifo_data(fifo_data), .data_avail(data_avail),
    .data_consume(data_consume), .tx_count(tx_count)
  );

  maple_tx_seq #(.START_PULSES(4), .TICK_DIV(3), .CNT_W(9)) dut3 (
    .clk(clk), .rst(rst), .pin1(pin1_3), .pin5(pin5_3), .oe(oe_3),
    .start_active(start_active_3), .end_active(end_active_3),
    .trigger_start(trigger_start), .trigger_end(trigger_end), .abort(abort),
    .tick(tick), .fifo_data(fifo_data), .data_avail(data_avail),
    .data_consume(data_consume_3), .tx_count(tx_count_3)
  );

  // Advance one clock; pops the FIFO model when the DUT consumed, clears pulses.
  task automatic cycle();
    logic pop;
    pop = data_consume;
    @(posedge clk);
    #1;
    trigger_start = 1'b0;
    trigger_end   = 1'b0;
    abort         = 1'b0;
    if (pop === 1'b1 && q.size() > 0) q.delete(0);
    data_avail = (q.size() != 0);
    fifo_data  = (q.size() != 0) ? q[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] b);
    q.push_back(b);
    data_avail = 1'b1;
    fifo_data  = q[0];
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick = 1'b1;
    q.delete();
    repeat (3) cycle();
    rst = 1'b0;
    cycle();
  endtask

  // Record line levels after each of the next 32 cycles (one data cell).
  task automatic capture_cell(output logic [31:0] p1, output logic [31:0] p5);
    for (int k = 0; k < 32; k++) begin
      cycle();
      p1[k] = pin1;
      p5[k] = pin5;
    end
  endtask

  function automatic logic [7:0] decode(input logic [31:0] p1, input logic [31:0] p5);
    logic [7:0] d;
    for (int i = 0; i < 8; i++) d[7-i] = (i % 2 == 0) ? p5[4*i] : p1[4*i];
    return d;
  endfunction

  // Bounded wait for start_active to fall; returns cycles taken, 0 on timeout.
  task automatic wait_start_done(output int n_out);
    n_out = 0;
    for (int n = 1; n <= 60; n++) begin
      cycle();
      if (!start_active) begin n_out = n; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    q.delete();
    push(8'h5A);
    repeat (3) cycle();
    checks++; if ({pin1, pin5} !== 2'b11) begin errors++; $display("FAIL reset_pins got=%b want=11", {pin1, pin5}); end
    checks++; if ({oe, start_active, end_active} !== 3'b000) begin errors++; $display("FAIL reset_ctl got=%b want=000", {oe, start_active, end_active}); end
    checks++; if (data_consume !== 1'b0) begin errors++; $display("FAIL reset_consume got=%b want=0", data_consume); end
    checks++; if (tx_count !== 9'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", tx_count); end
    rst = 1'b0;
    cycle();
    checks++; if ({oe, data_consume} !== 2'b00) begin errors++; $display("FAIL post_reset got=%b want=00", {oe, data_consume}); end
    q.delete();
    data_avail = 1'b0;
  endtask

  task automatic test_start_pattern();
    logic e1, e5;
    do_reset();
    trigger_start = 1'b1;
    cycle();
    checks++; if ({oe, start_active, end_active} !== 3'b110) begin errors++; $display("FAIL start_trig got=%b want=110", {oe, start_active, end_active}); end
    for (int k = 0; k < 28; k++) begin
      cycle();
      e1 = !(k >= 3 && k <= 25);
      e5 = !(k == 6 || k == 7 || k == 11 || k == 12 || k == 16 || k == 17 || k == 21 || k == 22);
      checks++; if (pin1 !== e1) begin errors++; $display("FAIL start_pin1 step=%0d got=%b want=%b", k, pin1, e1); end
      checks++; if (pin5 !== e5) begin errors++; $display("FAIL start_pin5 step=%0d got=%b want=%b", k, pin5, e5); end
      checks++; if (start_active !== (k != 27)) begin errors++; $display("FAIL start_active step=%0d got=%b want=%b", k, start_active, k != 27); end
    end
    cycle();
    checks++; if (oe !== 1'b1) begin errors++; $display("FAIL start_underrun_oe got=%b want=1", oe); end
  endtask

  task automatic test_frame();
    logic [31:0] p1, p5;
    int n;
    logic e1, e5;
    do_reset();
    push(8'hA5);
    push(8'h3C);
    trigger_start = 1'b1;
    cycle();
    wait_start_done(n);
    checks++; if (n != 28) begin errors++; $display("FAIL frame_start_len got=%0d want=28", n); end
    capture_cell(p1, p5);
    checks++; if (decode(p1, p5) !== 8'hA5) begin errors++; $display("FAIL frame_byte0 got=%h want=a5", decode(p1, p5)); end
    checks++; if ({p1[2], p5[3], p5[6], p1[7], p1[31]} !== 5'b01011) begin errors++; $display("FAIL frame_phases got=%b want=01011", {p1[2], p5[3], p5[6], p1[7], p1[31]}); end
    checks++; if (tx_count !== 9'd1) begin errors++; $display("FAIL frame_count1 got=%0d want=1", tx_count); end
    cycle();
    capture_cell(p1, p5);
    checks++; if (decode(p1, p5) !== 8'h3C) begin errors++; $display("FAIL frame_byte1 got=%h want=3c", decode(p1, p5)); end
    checks++; if (tx_count !== 9'd2) begin errors++; $display("FAIL frame_count2 got=%0d want=2", tx_count); end
    repeat (3) cycle();
    checks++; if ({oe, data_consume, pin1, pin5} !== 4'b1010) begin errors++; $display("FAIL frame_underrun got=%b want=1010", {oe, data_consume, pin1, pin5}); end
    trigger_end = 1'b1;
    cycle();
    checks++; if ({oe, end_active} !== 2'b11) begin errors++; $display("FAIL frame_trig_end got=%b want=11", {oe, end_active}); end
    cycle();
`ifdef MAPLE_TX_PARITY_EN
    capture_cell(p1, p5);
    checks++; if (decode(p1, p5) !== 8'h99) begin errors++; $display("FAIL frame_parity got=%h want=99", decode(p1, p5)); end
    checks++; if (tx_count !== 9'd2) begin errors++; $display("FAIL frame_parity_count got=%0d want=2", tx_count); end
`endif
    for (int k = 0; k < 17; k++) begin
      cycle();
      e5 = (k < 3) || (k >= 16);
      e1 = !(k == 6 || k == 7 || k == 11 || k == 12);
      checks++; if (pin5 !== e5) begin errors++; $display("FAIL end_pin5 step=%0d got=%b want=%b", k, pin5, e5); end
      checks++; if (pin1 !== e1) begin errors++; $display("FAIL end_pin1 step=%0d got=%b want=%b", k, pin1, e1); end
      checks++; if (oe !== (k < 16)) begin errors++; $display("FAIL end_oe step=%0d got=%b want=%b", k, oe, k < 16); end
    end
    checks++; if ({end_active, tx_count} !== {1'b0, 9'd2}) begin errors++; $display("FAIL frame_done got=%b/%0d want=0/2", end_active, tx_count); end
  endtask

  task automatic test_prescaler();
    int got;
    do_reset();
    trigger_start = 1'b1;
    cycle();
    got = 0;
    for (int n = 1; n <= 220; n++) begin
      tick = (n % 2 == 0);
      cycle();
      if (n == 23) begin
        checks++; if (pin1_3 !== 1'b1) begin errors++; $display("FAIL presc_pin1_before got=%b want=1", pin1_3); end
      end
      if (n == 24) begin
        checks++; if (pin1_3 !== 1'b0) begin errors++; $display("FAIL presc_pin1_step3 got=%b want=0", pin1_3); end
      end
      if (!start_active_3) begin got = n; break; end
    end
    tick = 1'b1;
    checks++; if (got != 168) begin errors++; $display("FAIL presc_start_len got=%0d want=168", got); end
  endtask

  task automatic test_abort();
    logic [31:0] p1, p5;
    int n;
    do_reset();
    push(8'hA5);
    push(8'h3C);
    trigger_start = 1'b1;
    cycle();
    wait_start_done(n);
    capture_cell(p1, p5);
    cycle();
    repeat (13) cycle();
    push(8'h5A);
    abort = 1'b1;
    cycle();
    checks++; if ({pin1, pin5, oe, data_consume} !== 4'b1100) begin errors++; $display("FAIL abort_lines got=%b want=1100", {pin1, pin5, oe, data_consume}); end
    checks++; if ({start_active, end_active} !== 2'b00) begin errors++; $display("FAIL abort_flags got=%b want=00", {start_active, end_active}); end
    checks++; if (tx_count !== 9'd1) begin errors++; $display("FAIL abort_count_held got=%0d want=1", tx_count); end
    repeat (2) cycle();
    trigger_start = 1'b1;
    cycle();
    checks++; if ({oe, start_active, tx_count} !== {2'b11, 9'd0}) begin errors++; $display("FAIL abort_restart got=%b/%0d want=11/0", {oe, start_active}, tx_count); end
    wait_start_done(n);
    checks++; if (n != 28) begin errors++; $display("FAIL abort_restart_len got=%0d want=28", n); end
    capture_cell(p1, p5);
    checks++; if (decode(p1, p5) !== 8'h5A) begin errors++; $display("FAIL abort_restart_byte got=%h want=5a", decode(p1, p5)); end
    checks++; if (tx_count !== 9'd1) begin errors++; $display("FAIL abort_restart_count got=%0d want=1", tx_count); end
  endtask

  task automatic test_start_end_empty();
    int n, got;
    do_reset();
    trigger_start = 1'b1;
    trigger_end   = 1'b1;
    cycle();
    checks++; if ({oe, start_active, end_active} !== 3'b111) begin errors++; $display("FAIL both_trig got=%b want=111", {oe, start_active, end_active}); end
    wait_start_done(n);
    checks++; if (n != 28) begin errors++; $display("FAIL both_start_len got=%0d want=28", n); end
    got = 0;
    for (int m = 1; m <= 100; m++) begin
      cycle();
      if (!oe) begin got = m; break; end
    end
    checks++; if (got != END_DONE_CYCLES) begin errors++; $display("FAIL both_oe_drop got=%0d want=%0d", got, END_DONE_CYCLES); end
    checks++; if ({end_active, pin1, pin5, tx_count} !== {3'b011, 9'd0}) begin errors++; $display("FAIL both_final got=%b/%0d want=011/0", {end_active, pin1, pin5}, tx_count); end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; trigger_start = 1'b0; trigger_end = 1'b0; abort = 1'b0;
    tick = 1'b1; data_avail = 1'b0; fifo_data = 8'h00;
    test_reset();
    test_start_pattern();
    test_frame();
    test_prescaler();
    test_abort();
    test_start_end_empty();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
